eth_mac_filter_multi: RTL and testbench
=======================================

// Module: eth_mac_filter_multi
// PURPOSE
//  Parametrised successor to the single-MAC stream filter. Compares the dst or src MAC of each
//  frame on a 10-bit ETH_STREAM {CKE,FRM,DAT[7:0]} against NUM_ENTRIES runtime-programmable MACs.
//  Matching frames go to OUT_ETH_STREAM_FILT; all others go to OUT_ETH_STREAM_OTHER.
//  Sits between the MAC receive path and the packet consumers.
// PARAMETERS
//  NUM_ENTRIES  4   number of MAC table entries (1..16)
//  IDX_W        2   width of entry index; must equal clog2(NUM_ENTRIES), minimum 1
//  MAC_OFFSET   6   byte offset of the compared MAC: 0 = dst, 6 = src
//  LAT          12  data delay in CKE beats; must be >= MAC_OFFSET+6
// PORTS
//  CLK                  in   1      master clock
//  RST                  in   1      synchronous, active-high reset
//  IN_ETH_STREAM        in   10     input stream {CKE,FRM,DAT}
//  CFG_WE               in   1      table write strobe, one CLK cycle
//  CFG_ADDR             in   IDX_W  table entry to write
//  CFG_MAC              in   48     MAC value; [47:40] is compared against the first MAC byte
//  CFG_VALID            in   1      valid bit written with the entry
//  OUT_ETH_STREAM_FILT  out  10     {CKE, FRM & match, DAT} after delay
//  OUT_ETH_STREAM_OTHER out  10     {CKE, FRM & !match, DAT} after delay
//  OUT_MATCH_IDX        out  IDX_W  lowest matching entry index; held for the whole frame
// BEHAVIOUR
//  Reset
//   - Both outputs = 10'h000, OUT_MATCH_IDX = 0.
//   - All table valid bits cleared, FRM delay line cleared, sync flag cleared.
//   - Reset mid-frame: the remainder of that frame is dropped. The sync flag sets on the first
//     CKE beat with FRM=0; no frame is processed until then.
//  Byte counter (4 bits, advances on CKE beats only)
//   - 0 while FRM=0; increments while FRM=1; saturates at 15.
//  Table writes
//   - CFG_WE writes the shadow table in one cycle.
//   - The active table is copied from the shadow on the CKE beat with FRM=1 and byte_cnt=0.
//   - A write during a frame therefore affects only the next frame.
//  Comparison
//   - Per-entry match bit is set at frame start (byte_cnt=0) if the active entry is valid.
//   - The bit is cleared on any CKE beat with byte_cnt in [MAC_OFFSET, MAC_OFFSET+5] and DAT
//     differing from the corresponding entry byte.
//   - Frame match = OR of match bits AND a complete MAC was seen (byte_cnt reached MAC_OFFSET+6).
//   - Frames shorter than MAC_OFFSET+6 bytes go to OTHER.
//  Outputs
//   - DAT and FRM are delayed LAT CKE beats, then registered every CLK.
//   - Output CKE is the registered in_cke, undelayed, exactly as the single-MAC filter.
//   - Per-frame match and index are latched into a LAT-deep pipeline together with FRM.
//   - The latched value is used for the entire delayed frame, so back-to-back frames separated
//     by one FRM=0 beat route independently.
//   - Exactly one of FILT.FRM / OTHER.FRM is high for every delayed FRM beat.
//  Match index
//   - Lowest-index matching entry (priority encoder).
//   - 0 when no entry matches; distinguish a real entry-0 match by FILT.FRM.
//  Simultaneous events
//   - CFG_WE on the same cycle as the copy: the copy takes the pre-write shadow; the new value
//     applies from the next frame.
//   - Duplicate entries: lowest index wins.
// CONFIGURATION
//  ETH_MAC_FILTER_CNT_EN defined:
//   - Adds outputs CNT_FILT[31:0] and CNT_OTHER[31:0].
//   - Each increments once per frame on the FRM falling edge at its output; wraps at 2^32.
//   - Both clear on RST.
//  ETH_MAC_FILTER_CNT_EN undefined: the counters and their ports do not exist.
// TESTING
//  1. Entry0=00_18_B7_00_00_01 valid, MAC_OFFSET=6; 64-byte frame with that src
//     -> frame on FILT, LAT+1 CLK later (CKE held high), OUT_MATCH_IDX=0, OTHER.FRM never high.
//  2. Same frame with last src byte 02 -> frame appears unchanged on OTHER, FILT.FRM=0 throughout.
//  3. Entries 1 and 3 both = MAC X, valid -> frame with src X gives OUT_MATCH_IDX=1.
//     Then invalidate entry 1 -> next frame gives idx=3.
//  4. Write entry0 mid-frame to that frame's MAC -> current frame on OTHER, next identical
//     frame on FILT.
//  5. 8-byte runt frame -> OTHER. CKE toggling 1-of-10 -> data identical, just slower.
//  6. Assert RST at byte 20 of a matching frame -> outputs 000 next cycle, rest of that frame
//     absent, next frame routed normally. With CNT_EN: CNT_FILT=0 after reset, then 1.

Source files
------------

// File: rtl/eth_mac_filter_multi.sv
// eth_mac_filter_multi: multi-entry MAC stream filter.
// Compares the dst (MAC_OFFSET=0) or src (MAC_OFFSET=6) MAC of each frame on a
// {CKE,FRM,DAT} stream against NUM_ENTRIES runtime-programmable entries and routes
// the frame, delayed by LAT CKE beats, to the FILT or OTHER output.
// Optional: define ETH_MAC_FILTER_CNT_EN to add per-output frame counters.
module eth_mac_filter_multi #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned MAC_OFFSET  = 6,
  parameter int unsigned LAT         = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [9:0]       IN_ETH_STREAM,
  input  logic             CFG_WE,
  input  logic [IDX_W-1:0] CFG_ADDR,
  input  logic [47:0]      CFG_MAC,
  input  logic             CFG_VALID,
  output logic [9:0]       OUT_ETH_STREAM_FILT,
  output logic [9:0]       OUT_ETH_STREAM_OTHER,
  output logic [IDX_W-1:0] OUT_MATCH_IDX
`ifdef ETH_MAC_FILTER_CNT_EN
  ,
  output logic [31:0]      CNT_FILT,
  output logic [31:0]      CNT_OTHER
`endif
);

  localparam int unsigned   PW       = (LAT > 2) ? $clog2(LAT) : 1;
  localparam logic [3:0]    DEC_CNT  = 4'(MAC_OFFSET + 5);
  localparam logic [PW-1:0] PTR_LAST = PW'(LAT - 1);

  logic       in_cke;
  logic       in_frm;
  logic [7:0] in_dat;

  assign in_cke = IN_ETH_STREAM[9];
  assign in_frm = IN_ETH_STREAM[8];
  assign in_dat = IN_ETH_STREAM[7:0];

  logic       sync_q;
  logic       frm_eff;
  logic       beat;
  logic       sof;
  logic [3:0] byte_cnt;

  // Frames seen before the first idle beat after reset are ignored entirely.
  assign frm_eff = in_frm & sync_q;
  assign beat    = in_cke & frm_eff;
  assign sof     = beat & (byte_cnt == 4'd0);

  // Sync flag: set on the first idle CKE beat after reset.
  always_ff @(posedge CLK) begin
    if (RST)
      sync_q <= 1'b0;
    else if (in_cke && !in_frm)
      sync_q <= 1'b1;
  end

  // Byte counter: position of the current byte within the frame, saturating.
  always_ff @(posedge CLK) begin
    if (RST)
      byte_cnt <= 4'd0;
    else if (in_cke) begin
      if (!frm_eff)
        byte_cnt <= 4'd0;
      else if (byte_cnt != 4'hF)
        byte_cnt <= byte_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------- tables
  logic [47:0]            shd_mac [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] shd_vld;
  logic [47:0]            act_mac [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] act_vld;

  // Shadow table MAC storage, written by the configuration port.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++)
      if (CFG_WE && (CFG_ADDR == IDX_W'(i)))
        shd_mac[i] <= CFG_MAC;
  end

  // Shadow table valid bits.
  always_ff @(posedge CLK) begin
    if (RST)
      shd_vld <= '0;
    else
      for (int unsigned i = 0; i < NUM_ENTRIES; i++)
        if (CFG_WE && (CFG_ADDR == IDX_W'(i)))
          shd_vld[i] <= CFG_VALID;
  end

  // Active table: snapshot of the shadow taken at each frame start (pre-write value).
  always_ff @(posedge CLK) begin
    if (RST)
      act_vld <= '0;
    else if (sof)
      act_vld <= shd_vld;
  end

  // Active table MAC snapshot.
  always_ff @(posedge CLK) begin
    if (sof)
      for (int unsigned i = 0; i < NUM_ENTRIES; i++)
        act_mac[i] <= shd_mac[i];
  end

  // ------------------------------------------------------------ comparison
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
    case (k)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

  int                     rel;
  logic                   in_rng;
  logic [2:0]             kidx;
  logic [NUM_ENTRIES-1:0] match_q;
  logic [NUM_ENTRIES-1:0] match_n;
  logic                   base;
  logic [47:0]            emac;

  // Per-entry match update; at frame start the table being copied is used directly.
  always_comb begin
    rel     = int'({28'd0, byte_cnt}) - int'(MAC_OFFSET);
    in_rng  = (rel >= 0) && (rel <= 5);
    kidx    = rel[2:0];
    match_n = '0;
    base    = 1'b0;
    emac    = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      base       = (byte_cnt == 4'd0) ? shd_vld[i] : match_q[i];
      emac       = (byte_cnt == 4'd0) ? shd_mac[i] : act_mac[i];
      match_n[i] = base & ~(in_rng & (in_dat != mac_byte(emac, kidx)));
    end
  end

  // Per-entry match bits, advanced on frame beats.
  always_ff @(posedge CLK) begin
    if (RST)
      match_q <= '0;
    else if (beat)
      match_q <= match_n;
  end

  logic [IDX_W-1:0] hit_idx;
  logic             hit_found;

  // Lowest-index matching entry.
  always_comb begin
    hit_idx   = '0;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++)
      if (match_n[i] && !hit_found) begin
        hit_idx   = IDX_W'(i);
        hit_found = 1'b1;
      end
  end

  // ---------------------------------------------------------- decision queue
  // The verdict is only known MAC_OFFSET+5 beats into a frame (or at a runt's end),
  // but must be applied from the first delayed byte. Verdicts are queued in frame
  // order and popped when the delayed start-of-frame leaves the delay line; since
  // LAT >= MAC_OFFSET+6 the verdict is always queued before it is needed.
  logic             dec_full;
  logic             dec_runt;
  logic             push;
  logic             push_m;
  logic [IDX_W-1:0] push_idx;

  assign dec_full = beat & (byte_cnt == DEC_CNT);
  assign dec_runt = in_cke & ~frm_eff & (byte_cnt != 4'd0) & (byte_cnt <= DEC_CNT);
  assign push     = dec_full | dec_runt;
  assign push_m   = dec_full & hit_found;
  assign push_idx = push_m ? hit_idx : '0;

  logic             dq_m   [LAT];
  logic [IDX_W-1:0] dq_idx [LAT];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;

  // Decision queue storage.
  always_ff @(posedge CLK) begin
    if (push) begin
      dq_m[wr_ptr]   <= push_m;
      dq_idx[wr_ptr] <= push_idx;
    end
  end

  // ------------------------------------------------------------ delay line
  logic [LAT-1:0] dl_frm;
  logic [LAT-1:0] dl_sof;
  logic [7:0]     dl_dat [LAT];

  // FRM/start/DAT delay line, shifted on CKE beats.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dl_frm <= '0;
      dl_sof <= '0;
      for (int unsigned i = 0; i < LAT; i++)
        dl_dat[i] <= '0;
    end else if (in_cke) begin
      dl_frm    <= {dl_frm[LAT-2:0], frm_eff};
      dl_sof    <= {dl_sof[LAT-2:0], sof};
      dl_dat[0] <= in_dat;
      for (int unsigned i = 1; i < LAT; i++)
        dl_dat[i] <= dl_dat[i-1];
    end
  end

  assign pop = in_cke & dl_frm[LAT-1] & dl_sof[LAT-1];

  logic             cur_m;
  logic [IDX_W-1:0] cur_idx;
  logic             route_m;
  logic [IDX_W-1:0] route_idx;

  // Queue pointers and the verdict held for the frame currently leaving the delay.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cur_m   <= 1'b0;
      cur_idx <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (pop) begin
        cur_m   <= dq_m[rd_ptr];
        cur_idx <= dq_idx[rd_ptr];
        rd_ptr  <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
    end
  end

  // Routing: start-of-frame takes the queue head, later bytes the held verdict.
  always_comb begin
    route_m   = cur_m;
    route_idx = cur_idx;
    if (dl_sof[LAT-1]) begin
      route_m   = dq_m[rd_ptr];
      route_idx = dq_idx[rd_ptr];
    end
  end

  // Output registers; CKE is the registered input CKE, undelayed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_ETH_STREAM_FILT  <= '0;
      OUT_ETH_STREAM_OTHER <= '0;
      OUT_MATCH_IDX        <= '0;
    end else begin
      OUT_ETH_STREAM_FILT  <= {in_cke, dl_frm[LAT-1] &  route_m, dl_dat[LAT-1]};
      OUT_ETH_STREAM_OTHER <= {in_cke, dl_frm[LAT-1] & ~route_m, dl_dat[LAT-1]};
      if (dl_frm[LAT-1])
        OUT_MATCH_IDX <= route_idx;
    end
  end

`ifdef ETH_MAC_FILTER_CNT_EN
  logic filt_frm_q;
  logic other_frm_q;

  // Frame counters: one count per FRM falling edge at each output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_frm_q  <= 1'b0;
      other_frm_q <= 1'b0;
      CNT_FILT    <= '0;
      CNT_OTHER   <= '0;
    end else begin
      filt_frm_q  <= OUT_ETH_STREAM_FILT[8];
      other_frm_q <= OUT_ETH_STREAM_OTHER[8];
      if (filt_frm_q && !OUT_ETH_STREAM_FILT[8])
        CNT_FILT <= CNT_FILT + 32'd1;
      if (other_frm_q && !OUT_ETH_STREAM_OTHER[8])
        CNT_OTHER <= CNT_OTHER + 32'd1;
    end
  end
`else
  // Frame counters not built.
`endif

endmodule

// File: tb/tb_eth_mac_filter_multi.sv
// Directed self-checking bench for eth_mac_filter_multi (default parameters).
module tb_eth_mac_filter_multi;

  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  in_stream = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [47:0] cfg_mac = '0;
  logic        cfg_valid = 1'b0;
  logic [9:0]  filt_o;
  logic [9:0]  other_o;
  logic [1:0]  idx_o;
`ifdef ETH_MAC_FILTER_CNT_EN
  logic [31:0] cnt_f;
  logic [31:0] cnt_o;
`endif

  eth_mac_filter_multi #(
    .NUM_ENTRIES(4),
    .IDX_W(2),
    .MAC_OFFSET(6),
    .LAT(LAT)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .IN_ETH_STREAM(in_stream),
    .CFG_WE(cfg_we),
    .CFG_ADDR(cfg_addr),
    .CFG_MAC(cfg_mac),
    .CFG_VALID(cfg_valid),
    .OUT_ETH_STREAM_FILT(filt_o),
    .OUT_ETH_STREAM_OTHER(other_o),
    .OUT_MATCH_IDX(idx_o)
`ifdef ETH_MAC_FILTER_CNT_EN
    ,
    .CNT_FILT(cnt_f),
    .CNT_OTHER(cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: collects frames on each output at CKE beats.
  int         f_frames = 0, o_frames = 0, f_len = 0, o_len = 0;
  int         f_last_len = 0, o_last_len = 0, f_first_cyc = 0, both_hi = 0;
  logic [1:0] f_idx = '0;
  logic [7:0] f_buf [64];
  logic [7:0] o_buf [64];

  always @(negedge clk) begin
    if (filt_o[8] && other_o[8]) both_hi++;
    if (filt_o[9]) begin
      if (filt_o[8]) begin
        if (f_len == 0) begin
          f_first_cyc = cyc;
          f_idx       = idx_o;
        end
        if (f_len < 64) f_buf[f_len] = filt_o[7:0];
        f_len++;
      end else if (f_len != 0) begin
        f_frames++;
        f_last_len = f_len;
        f_len      = 0;
      end
      if (other_o[8]) begin
        if (o_len < 64) o_buf[o_len] = other_o[7:0];
        o_len++;
      end else if (o_len != 0) begin
        o_frames++;
        o_last_len = o_len;
        o_len      = 0;
      end
    end
  end

  logic [7:0] tx_buf [64];
  int         t0 = 0;

  task automatic build(input logic [47:0] src, input int len);
    logic [47:0] tmp;
    tmp = src;
    for (int i = 0; i < len; i++) tx_buf[i] = 8'((i * 7) + 3);
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    tx_buf[3] = 8'h00; tx_buf[4] = 8'h00; tx_buf[5] = 8'hAA;
    for (int k = 0; k < 6; k++) begin
      if (6 + k < len) tx_buf[6 + k] = tmp[47:40];
      tmp = tmp << 8;
    end
  endtask

  function automatic int diff_cnt(input bit use_filt, input int len);
    int d = 0;
    for (int i = 0; i < len; i++)
      if ((use_filt ? f_buf[i] : o_buf[i]) !== tx_buf[i]) d++;
    return d;
  endfunction

  task automatic drive(input logic cke, input logic frm, input logic [7:0] d,
                       input logic we, input logic r);
    @(posedge clk);
    #1;
    in_stream = {cke, frm, d};
    cfg_we    = we;
    rst       = r;
  endtask

  task automatic wr_entry(input logic [1:0] a, input logic [47:0] m, input logic v);
    cfg_addr  = a;
    cfg_mac   = m;
    cfg_valid = v;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int len, input bit slow, input int idle,
                            input int wr_byte, input int rst_byte);
    for (int i = 0; i < len; i++) begin
      if (slow) repeat (9) drive(1'b0, 1'b1, tx_buf[i], 1'b0, 1'b0);
      drive(1'b1, 1'b1, tx_buf[i], 1'(i == wr_byte), 1'(i == rst_byte));
      if (i == 0) t0 = cyc;
      if (rst_byte >= 0 && i == rst_byte + 1) begin
        check_eq("rst_mid_filt", filt_o, 10'h000);
        check_eq("rst_mid_other", other_o, 10'h000);
        check_eq("rst_mid_idx", idx_o, 2'd0);
`ifdef ETH_MAC_FILTER_CNT_EN
        check_eq("rst_mid_cnt_filt", cnt_f, 32'd0);
`endif
      end
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (idle) drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  localparam logic [47:0] MAC_A  = 48'h00_18_B7_00_00_01;
  localparam logic [47:0] MAC_A2 = 48'h00_18_B7_00_00_02;
  localparam logic [47:0] MAC_X  = 48'h02_11_22_33_44_55;
  localparam logic [47:0] MAC_Y  = 48'h00_18_C0_FF_EE_07;
  localparam logic [47:0] MAC_Z  = 48'h00_18_C0_FF_EE_08;

  int fc, oc;

  initial begin
    // Reset state
    repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("reset_filt", filt_o, 10'h000);
    check_eq("reset_other", other_o, 10'h000);
    check_eq("reset_idx", idx_o, 2'd0);
    repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Matching 64-byte frame
    wr_entry(2'd0, MAC_A, 1'b1);
    build(MAC_A, 64);
    send_frame(64, 1'b0, LAT + 4, -1, -1);
    check_eq("t1_filt_frames", f_frames, 1);
    check_eq("t1_other_frames", o_frames, 0);
    check_eq("t1_len", f_last_len, 64);
    check_eq("t1_data", diff_cnt(1'b1, 64), 0);
    check_eq("t1_idx", f_idx, 2'd0);
    check_eq("t1_latency", f_first_cyc - t0, LAT + 1);

    // Last src byte differs
    build(MAC_A2, 64);
    send_frame(64, 1'b0, LAT + 4, -1, -1);
    check_eq("t2_filt_frames", f_frames, 1);
    check_eq("t2_other_frames", o_frames, 1);
    check_eq("t2_len", o_last_len, 64);
    check_eq("t2_data", diff_cnt(1'b0, 64), 0);

    // Shortest frame holding the full MAC, and one byte shorter
    build(MAC_A, 12);
    send_frame(12, 1'b0, LAT + 4, -1, -1);
    check_eq("len12_filt_frames", f_frames, 2);
    build(MAC_A, 11);
    send_frame(11, 1'b0, LAT + 4, -1, -1);
    check_eq("len11_other_frames", o_frames, 2);
    check_eq("len11_filt_frames", f_frames, 2);

    // Duplicate entries: lowest wins, then invalidate
    wr_entry(2'd1, MAC_X, 1'b1);
    wr_entry(2'd3, MAC_X, 1'b1);
    build(MAC_X, 24);
    send_frame(24, 1'b0, LAT + 4, -1, -1);
    check_eq("t3_filt_frames", f_frames, 3);
    check_eq("t3_idx_dup", f_idx, 2'd1);
    wr_entry(2'd1, MAC_X, 1'b0);
    send_frame(24, 1'b0, LAT + 4, -1, -1);
    check_eq("t3_filt_frames2", f_frames, 4);
    check_eq("t3_idx_inval", f_idx, 2'd3);

    // Table write mid-frame applies from the next frame
    cfg_addr = 2'd0; cfg_mac = MAC_Y; cfg_valid = 1'b1;
    build(MAC_Y, 32);
    send_frame(32, 1'b0, LAT + 4, 20, -1);
    check_eq("t4_cur_other", o_frames, 3);
    check_eq("t4_cur_filt", f_frames, 4);
    send_frame(32, 1'b0, LAT + 4, -1, -1);
    check_eq("t4_next_filt", f_frames, 5);
    check_eq("t4_next_idx", f_idx, 2'd0);

    // Runt and slow CKE
    build(MAC_Y, 8);
    send_frame(8, 1'b0, LAT + 4, -1, -1);
    check_eq("t5_runt_other", o_frames, 4);
    check_eq("t5_runt_len", o_last_len, 8);
    build(MAC_Y, 20);
    send_frame(20, 1'b1, LAT + 4, -1, -1);
    check_eq("t5_slow_filt", f_frames, 6);
    check_eq("t5_slow_len", f_last_len, 20);
    check_eq("t5_slow_data", diff_cnt(1'b1, 20), 0);

    // Back-to-back frames with a single idle beat route independently
    build(MAC_Y, 14);
    send_frame(14, 1'b0, 0, -1, -1);
    build(MAC_Z, 15);
    send_frame(15, 1'b0, LAT + 4, -1, -1);
    check_eq("b2b_filt_frames", f_frames, 7);
    check_eq("b2b_filt_len", f_last_len, 14);
    check_eq("b2b_other_frames", o_frames, 5);
    check_eq("b2b_other_len", o_last_len, 15);

    // Reset at byte 20 of a matching frame; entry rewritten while unsynced
    fc = f_frames;
    oc = o_frames;
    cfg_addr = 2'd0; cfg_mac = MAC_Y; cfg_valid = 1'b1;
    build(MAC_Y, 64);
    send_frame(64, 1'b0, LAT + 4, 30, 20);
    check_eq("t6_trunc_frames", f_frames, fc + 1);
    check_eq("t6_trunc_len", f_last_len, 8);
    check_eq("t6_no_other", o_frames, oc);
    send_frame(64, 1'b0, LAT + 4, -1, -1);
    check_eq("t6_next_filt", f_frames, fc + 2);
    check_eq("t6_next_len", f_last_len, 64);
    check_eq("t6_next_data", diff_cnt(1'b1, 64), 0);
    check_eq("t6_next_other", o_frames, oc);
`ifdef ETH_MAC_FILTER_CNT_EN
    check_eq("t6_cnt_filt", cnt_f, 32'd1);
`endif

    check_eq("exclusive_frm", both_hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
